// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width and FSM state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping to 0.
module rr_priority_picker #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  // First pass covers ptr..NUM_REQ-1, second pass the wrapped part 0..ptr-1.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        pick[i] = 1'b1;
        any     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[i]) begin
        pick[i] = 1'b1;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte serializer among NUM_REQ sources,
// with a per-grant byte limit and a programmable idle gap between packets.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MAX_PKT    = 64,
  parameter int GAP_CYCLES = 0
) (
  input  logic                           osc_12m,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           pkt_trunc
);

  localparam int                PTR_W     = $clog2(NUM_REQ);
  localparam int                CNT_W     = $clog2(MAX_PKT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_PKT - 1);
  localparam logic [15:0]       GAP_LOAD  = 16'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);

  state_t                 state, state_nxt;
  logic [PTR_W-1:0]       rr_ptr, g_idx, pick_idx;
  logic [CNT_W-1:0]       byte_cnt;
  logic [15:0]            gap_cnt;
  logic [NUM_REQ-1:0]     pick;
  logic                   pick_any;
  logic                   g_valid, g_last;
  logic [UART_BYTE_W-1:0] g_data;
  logic                   xfer_fire, at_limit, pkt_end;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (pick_any)
  );

  // Owner mux driven by the registered grant index; also encodes the picker's one-hot result.
  always_comb begin
    g_valid  = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_idx == PTR_W'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[UART_BYTE_W*i +: UART_BYTE_W];
      end
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    if (state == ST_XFER) begin
      tx_valid = g_valid;
      tx_data  = g_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (g_idx == PTR_W'(i)) req_ready[i] = tx_ready;
      end
    end
  end

  assign xfer_fire = (state == ST_XFER) && g_valid && tx_ready;
  assign at_limit  = (byte_cnt == CNT_LIMIT);
  assign pkt_end   = xfer_fire && (g_last || at_limit);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pick_any) state_nxt = ST_XFER;
      ST_XFER: if (pkt_end) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (gap_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge osc_12m or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Grant, round-robin pointer and counters; grant is cleared on the packet-ending transfer.
  always_ff @(posedge osc_12m or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      g_idx     <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      pkt_trunc <= 1'b0;
    end else begin
      pkt_trunc <= pkt_end && at_limit && !g_last;
      if (state == ST_IDLE && pick_any) begin
        grant <= pick;
        g_idx <= pick_idx;
      end
      if (pkt_end) begin
        grant    <= '0;
        byte_cnt <= '0;
        rr_ptr   <= (g_idx == PTR_LAST) ? '0 : g_idx + PTR_W'(1);
        gap_cnt  <= GAP_LOAD;
      end else if (xfer_fire) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end
      if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 16'd1;
    end
  end

endmodule
